// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe -- two-stage pipelined ALU with valid/ready handshakes.
//
// Stage 1 captures operands and opcode. Stage 2 computes the result and
// registers it with its flags. Latency is 2 cycles and throughput is
// 1 op/cycle. Backpressure from out_ready stalls stage 2 first, then
// stage 1, then in_ready drops.
//
// Optional feature (macro ALU_PIPE_ADC_EN): an internal carry register
// c_reg, updated by ADD/SUB/ADC, that enables opcode 110 = ADC. When the
// macro is undefined, opcode 110 is invalid.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand/opcode valid
//   in_ready   block can accept this cycle (combinational)
//   a, b       operands (WIDTH bits)
//   sel        opcode (3 bits)
//   out_valid  result valid
//   out_ready  consumer accepts result
//   result     registered result (WIDTH bits)
//   carry_out  registered carry / not-borrow
//   overflow   registered signed overflow
//   zero       registered, result == 0
//   err        registered, invalid opcode
// ---------------------------------------------------------------------------
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             err
);

  localparam int MSB = WIDTH - 1;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_NOT = 3'b100,
    OP_XOR = 3'b101,
    OP_ADC = 3'b110,
    OP_INV = 3'b111
  } op_e;

  // Stage-1 registers
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  op_e              s1_sel;

  logic s1_adv;
  logic accept;

`ifdef ALU_PIPE_ADC_EN
  logic c_reg;
`endif

  // Stage 1 moves forward whenever stage 2 is empty or being drained.
  assign s1_adv   = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s1_adv;
  assign accept   = in_valid && in_ready;

  // ---------------------------------------------------------------------
  // Stage 1: valid bit (reset) and data (no reset)
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // NOTE: the data registers carry no reset; they are only observed when
  // s1_valid is set, so resetting them would cost routing for no benefit.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_a   <= a;
      s1_b   <= b;
      s1_sel <= op_e'(sel);
    end
  end

  // ---------------------------------------------------------------------
  // Execute (combinational from stage-1 registers)
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] b_op;
  logic             cin;
  logic             arith;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] nx_result;
  logic             nx_carry;
  logic             nx_ovf;
  logic             nx_err;

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    b_op      = s1_b;
    cin       = 1'b0;
    arith     = 1'b0;
    nx_result = '0;
    nx_carry  = 1'b0;
    nx_ovf    = 1'b0;
    nx_err    = 1'b0;

    unique case (s1_sel)
      OP_ADD: arith = 1'b1;
      OP_SUB: begin
        // a - b as a + ~b + 1, so carry is the not-borrow
        arith = 1'b1;
        b_op  = ~s1_b;
        cin   = 1'b1;
      end
      OP_AND: nx_result = s1_a & s1_b;
      OP_OR:  nx_result = s1_a | s1_b;
      OP_NOT: nx_result = ~s1_a;
      OP_XOR: nx_result = s1_a ^ s1_b;
`ifdef ALU_PIPE_ADC_EN
      OP_ADC: begin
        arith = 1'b1;
        cin   = c_reg;
      end
`endif
      default: nx_err = 1'b1;
    endcase

    sum = {1'b0, s1_a} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};

    if (arith) begin
      nx_result = sum[MSB:0];
      nx_carry  = sum[WIDTH];
      // Same rule covers ADD/ADC and SUB because b_op is already inverted
      // for SUB: effective operand signs equal, result sign differs.
      nx_ovf    = (s1_a[MSB] == b_op[MSB]) && (sum[MSB] != s1_a[MSB]);
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: result and flags
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      err       <= 1'b0;
    end else if (s1_adv) begin
      out_valid <= 1'b1;
      result    <= nx_result;
      carry_out <= nx_carry;
      overflow  <= nx_ovf;
      zero      <= (nx_result == '0);
      err       <= nx_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ALU_PIPE_ADC_EN
  // Carry chain register: follows arithmetic ops only, so ADD -> AND -> ADC
  // still consumes the ADD carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_reg <= 1'b0;
    end else if (s1_adv && arith) begin
      c_reg <= nx_carry;
    end
  end
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_pipe -- self-checking bench for alu_pipe (WIDTH = 8).
// Directed vector table, latency/backpressure/reset sequences, and random
// traffic scored against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_alu_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   sel = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         zero;
  logic         err;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         o;
    logic         z;
    logic         e;
  } out_t;

  typedef struct {
    logic [2:0]   sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    out_t         exp;
  } vec_t;

  out_t exp_q[$];
  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;
  int   model_carry = 0;
  bit   accepted;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the opcode rules.
  task automatic model(input logic [2:0] op, input int x, input int y, output out_t r);
    int m, half, sx, sy, s, ss, rv;
    bit c, o, e, upd;
    m    = (1 << W) - 1;
    half = 1 << (W - 1);
    sx   = (x >= half) ? x - (1 << W) : x;
    sy   = (y >= half) ? y - (1 << W) : y;
    rv = 0; c = 0; o = 0; e = 0; upd = 0;
    case (op)
      3'd0: begin
        s = x + y; rv = s & m; c = (s > m);
        ss = sx + sy; o = (ss >= half) || (ss < -half); upd = 1;
      end
      3'd1: begin
        rv = (x - y) & m; c = (x >= y);
        ss = sx - sy; o = (ss >= half) || (ss < -half); upd = 1;
      end
      3'd2: rv = x & y;
      3'd3: rv = x | y;
      3'd4: rv = (~x) & m;
      3'd5: rv = x ^ y;
`ifdef ALU_PIPE_ADC_EN
      3'd6: begin
        s = x + y + model_carry; rv = s & m; c = (s > m);
        ss = sx + sy + model_carry; o = (ss >= half) || (ss < -half); upd = 1;
      end
`endif
      default: e = 1;
    endcase
    if (upd) model_carry = c;
    r = '{res: rv[W-1:0], c: c, o: o, z: (rv == 0), e: e};
  endtask

  function automatic vec_t mk(input logic [2:0] s, input logic [W-1:0] x, input logic [W-1:0] y,
                              input logic [W-1:0] res, input logic c, input logic o,
                              input logic z, input logic e);
    vec_t v;
    v.sel = s; v.a = x; v.b = y;
    v.exp = '{res: res, c: c, o: o, z: z, e: e};
    return v;
  endfunction

  task automatic drive(input bit v, input logic [2:0] s, input logic [W-1:0] x, input logic [W-1:0] y);
    in_valid = v; sel = s; a = x; b = y;
  endtask

  // One clock: observe at negedge (score output, record acceptance), then
  // return 1 time unit after the next rising edge.
  task automatic cycle(input bit use_model, input out_t tab_exp);
    out_t got, r;
    @(negedge clk);
    accepted = in_valid && in_ready;
    if (out_valid && out_ready) begin
      got = '{res: result, c: carry_out, o: overflow, z: zero, e: err};
      if (exp_q.size() == 0) begin
        errors++; checks++;
        $display("FAIL unexpected_out: got result %0h with no op outstanding", result);
      end else begin
        r = exp_q.pop_front();
        check("result_flags", 32'(got), 32'(r));
      end
    end
    if (accepted) begin
      model(sel, 32'(a), 32'(b), r);
      if (!use_model) r = tab_exp;
      exp_q.push_back(r);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) cycle(1, '0);
    check("drain_empty", 32'(exp_q.size()), 0);
    repeat (2) cycle(1, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] held;
    logic [2:0]   bp_sel [3];
    logic [W-1:0] bp_a [3];
    logic [W-1:0] bp_b [3];
    int           idx;

    // Directed vectors: {sel, a, b, result, carry, overflow, zero, err}
    tbl.push_back(mk(3'b000, 8'hF0, 8'h20, 8'h10, 1, 0, 0, 0));
    tbl.push_back(mk(3'b001, 8'h05, 8'h05, 8'h00, 1, 0, 1, 0));
    tbl.push_back(mk(3'b001, 8'h80, 8'h01, 8'h7F, 1, 1, 0, 0));
    tbl.push_back(mk(3'b010, 8'hCC, 8'hAA, 8'h88, 0, 0, 0, 0));
    tbl.push_back(mk(3'b011, 8'hCC, 8'hAA, 8'hEE, 0, 0, 0, 0));
    tbl.push_back(mk(3'b101, 8'hCC, 8'hAA, 8'h66, 0, 0, 0, 0));
    tbl.push_back(mk(3'b100, 8'h0F, 8'h5A, 8'hF0, 0, 0, 0, 0));
    tbl.push_back(mk(3'b111, 8'h12, 8'h34, 8'h00, 0, 0, 1, 1));
    tbl.push_back(mk(3'b000, 8'h7F, 8'h01, 8'h80, 0, 1, 0, 0));
    tbl.push_back(mk(3'b001, 8'h00, 8'h01, 8'hFF, 0, 0, 0, 0));
`ifdef ALU_PIPE_ADC_EN
    tbl.push_back(mk(3'b000, 8'hFF, 8'h01, 8'h00, 1, 0, 1, 0));
    tbl.push_back(mk(3'b110, 8'h00, 8'h00, 8'h01, 0, 0, 0, 0));
`else
    tbl.push_back(mk(3'b110, 8'h55, 8'h66, 8'h00, 0, 0, 1, 1));
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_result", 32'(result), 0);
    check("rst_flags", 32'({carry_out, overflow, zero, err}), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back table stream with out_ready high
    out_ready = 1'b1;
    foreach (tbl[i]) begin
      drive(1, tbl[i].sel, tbl[i].a, tbl[i].b);
      check("stream_in_ready", 32'(in_ready), 1);
      cycle(0, tbl[i].exp);
    end
    drain();

    // Latency: accepted in cycle N, out_valid in cycle N+2
    drive(1, 3'b000, 8'h01, 8'h02);
    cycle(1, '0);
    check("lat_accept", 32'(accepted), 1);
    in_valid = 1'b0;
    check("lat_n1_valid", 32'(out_valid), 0);
    cycle(1, '0);
    check("lat_n2_valid", 32'(out_valid), 1);
    drain();

    // Backpressure: 3 ops offered while out_ready is low for 4 cycles
    for (int i = 0; i < 3; i++) begin
      bp_sel[i] = 3'($urandom_range(0, 5));
      bp_a[i]   = W'($urandom);
      bp_b[i]   = W'($urandom);
    end
    out_ready = 1'b0;
    idx = 0;
    held = '0;
    for (int c = 0; c < 4; c++) begin
      drive(1, bp_sel[idx], bp_a[idx], bp_b[idx]);
      cycle(1, '0);
      if (accepted) idx++;
      if (c == 1) held = result;
    end
    check("bp_accepted", 32'(idx), 2);
    check("bp_in_ready_low", 32'(in_ready), 0);
    check("bp_out_valid", 32'(out_valid), 1);
    check("bp_result_stable", 32'(result), 32'(held));
    out_ready = 1'b1;
    for (int c = 0; c < 5 && idx < 3; c++) begin
      drive(1, bp_sel[idx], bp_a[idx], bp_b[idx]);
      cycle(1, '0);
      if (accepted) idx++;
    end
    check("bp_third_accepted", 32'(idx), 3);
    drain();

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom), W'($urandom), W'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      cycle(1, '0);
    end
    drain();

    // Reset mid-stream
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 3'($urandom_range(0, 5)), W'($urandom), W'($urandom));
      cycle(1, '0);
    end
    check("pre_reset_valid", 32'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_out_valid", 32'(out_valid), 0);
    check("mid_reset_in_ready", 32'(in_ready), 1);
    exp_q.delete();
    model_carry = 0;
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(1, '0);
      check("post_reset_no_valid", 32'(out_valid), 0);
    end
    drive(1, 3'b000, 8'h03, 8'h04);
    cycle(1, '0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
